// File: rtl/calculate_sched_pkg.sv
// Shared types and constants for the calculate round-robin scheduler.
package calculate_sched_pkg;

    localparam int CALC_W      = 32;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/calculate_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [NREQ-1:0] rot;
    int              sel;

    // Rotate so bit 0 is the requester at ptr, take the lowest set bit, map back.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        any   = 1'b0;
        sel   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sel = i;
            end
        end
        idx   = IDW'((int'(ptr) + sel) % NREQ);
        grant = '0;
        for (int j = 0; j < NREQ; j++) begin
            grant[j] = any && (idx == IDW'(j));
        end
    end

endmodule

// File: rtl/calculate_rr_sched.sv
// Round-robin scheduler sharing one ap_ctrl_hs `calculate` core between requesters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | pick a requester, latch its operands, pulse req_ready
//   S_START | core_ap_start high, combinational core completes here
//   S_WAIT  | waiting on ap_done; watchdog counts toward TIMEOUT-1
//   S_RESP  | result presented, held until resp_ready
module calculate_rr_sched
    import calculate_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CALC_W-1:0] req_a,
    input  logic [NREQ*CALC_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [CALC_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic                   core_ap_start,
    output logic [CALC_W-1:0]      core_a,
    output logic [CALC_W-1:0]      core_b,
    input  logic                   core_ap_done,
    input  logic                   core_ap_ready,
    input  logic                   core_ap_idle,
    input  logic [CALC_W-1:0]      core_ap_return,
    output logic                   busy
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_e      state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic [CALC_W-1:0] core_a_q, core_a_d;
    logic [CALC_W-1:0] core_b_q, core_b_d;
    logic [CALC_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              start_q, start_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;

    // ap_idle carries nothing the scheduler needs; done/ready fully describe the core.
    logic              unused_idle;
    assign unused_idle = core_ap_idle;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // State register and datapath flops.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            resp_id_q   <= '0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            start_q     <= 1'b0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            resp_id_q   <= resp_id_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            start_q     <= start_d;
            wcnt_q      <= wcnt_d;
        end
    end

    // Next-state and datapath updates; done beats the watchdog when both hit.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        resp_id_d   = resp_id_q;
        core_a_d    = core_a_q;
        core_b_d    = core_b_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        start_d     = start_q;
        wcnt_d      = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    for (int j = 0; j < NREQ; j++) begin
                        if (grant[j]) begin
                            core_a_d = req_a[j*CALC_W +: CALC_W];
                            core_b_d = req_b[j*CALC_W +: CALC_W];
                        end
                    end
                    resp_id_d = grant_idx;
                    start_d   = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                wcnt_d = '0;
                if (core_ap_done) begin
                    resp_data_d = core_ap_return;
                    resp_err_d  = 1'b0;
                    start_d     = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    if (core_ap_ready) begin
                        start_d = 1'b0;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCW'(1);
                if (core_ap_ready) begin
                    start_d = 1'b0;
                end
                if (core_ap_done) begin
                    resp_data_d = core_ap_return;
                    resp_err_d  = 1'b0;
                    start_d     = 1'b0;
                    state_d     = S_RESP;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    start_d     = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                start_d = 1'b0;
                if (resp_ready) begin
                    ptr_d   = (resp_id_q == IDW'(NREQ - 1)) ? '0 : resp_id_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready only ever pulses in IDLE.
    always_comb begin
        req_ready  = (state_q == S_IDLE) ? grant : '0;
        resp_valid = (state_q == S_RESP);
        busy       = (state_q != S_IDLE);
    end

    assign resp_id       = resp_id_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;
    assign core_ap_start = start_q;
    assign core_a        = core_a_q;
    assign core_b        = core_b_q;

endmodule

// File: doc/calculate_rr_sched.md
Name: calculate_rr_sched

Overview:
- Round-robin scheduler that shares one `calculate` core (ap_ctrl_hs handshake, 32-bit a/b in, 32-bit ap_return out) between NREQ requesters.
- Accepts one operand pair at a time, drives the core's ap_start handshake, captures ap_return into a registered response buffer, and tags the result with the requester index.
- Sits between requester logic and a single `calculate` instance, combinational or multi-cycle.
- A watchdog flags a core that never completes.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: requester-index width, equal to clog2(NREQ) and at least 1.
- TIMEOUT, 16: max cycles in WAIT before abort; at least 1.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*32  operand a; requester i occupies bits [32i+31:32i].
- req_b  in  NREQ*32  operand b, same packing as req_a.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index of result.
- resp_data  out  32  captured core ap_return.
- resp_err  out  1  1 = watchdog abort; resp_data = 0.
- core_ap_start  out  1  to core ap_start.
- core_a  out  32  to core a; registered.
- core_b  out  32  to core b; registered.
- core_ap_done  in  1  from core.
- core_ap_ready  in  1  from core; tracked, not required.
- core_ap_idle  in  1  from core; ignored.
- core_ap_return  in  32  from core.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, ap_clk. ap_rst is synchronous and active-high.
- Reset values:
  - FSM state = IDLE.
  - Round-robin pointer ptr = 0.
  - req_ready = 0, resp_valid = 0, resp_err = 0, core_ap_start = 0.
  - resp_id = 0, resp_data = 0, core_a = 0, core_b = 0, busy = 0.
  - Watchdog counter wcnt = 0.
- Reset mid-operation: everything returns to the reset values next edge. An in-flight core result is discarded and core_ap_start drops.
- FSM states are IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick grant g = first set bit searching ptr, ptr+1, ... with wrap modulo NREQ.
  - req_ready[g] = 1 combinationally in this cycle only; the requester's transfer completes here.
  - Register core_a = req_a[g], core_b = req_b[g], resp_id = g.
  - Go to START.
- START:
  - core_ap_start = 1 (registered, asserted for the whole state), wcnt = 0.
  - If core_ap_done = 1 this cycle, capture resp_data = core_ap_return and resp_err = 0, then go to RESP. A combinational core always takes this path.
  - Otherwise go to WAIT.
- WAIT:
  - core_ap_start stays 1 until core_ap_ready has been seen, then drops to 0 (ap_ctrl_hs rule).
  - wcnt increments every cycle.
  - On core_ap_done: capture as in START, go to RESP.
  - If wcnt reaches TIMEOUT-1 with no done: resp_data = 0, resp_err = 1, core_ap_start = 0, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - resp_valid = 1; resp_data, resp_id and resp_err are held stable.
  - On resp_ready = 1: ptr = (resp_id + 1) mod NREQ, go to IDLE.
  - core_ap_start = 0 throughout.
- Latency with a combinational core:
  - Accept at cycle T, START at T+1, resp_valid at T+2.
  - Peak throughput is one result per 3 cycles.
- Fairness: requester i waits at most NREQ-1 grants.
- Request and response rules:
  - req_ready is never asserted outside IDLE.
  - A requester that drops req_valid before being granted is simply not served.
- busy = (state != IDLE).

Decomposition:
- Package calculate_sched_pkg:
  - FSM state enum, 2 bits: IDLE=0, START=1, WAIT=2, RESP=3.
  - Default constants for NREQ and TIMEOUT.
  - Data width constant CALC_W = 32.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, binary index, any.

Test Plan:
- Single request, combinational core model with correct key:
  - req_valid=0001, a=0x00000000, b=1.
  - req_ready[0] at T; core_ap_start at T+1.
  - resp_valid at T+2 with resp_data=0xFE9AA4C9 (value > threshold path), resp_id=0, resp_err=0.
- Wrap/add path:
  - Requester 2, a=0x01655B37, b=5; the internal sum wraps to 0.
  - Expect resp_data=0x00000005, resp_id=2.
- Round-robin fairness:
  - req_valid=1111 held, resp_ready=1.
  - Grant order is 0,1,2,3,0; each response id matches its grant; results spaced 3 cycles apart.
- Backpressure:
  - resp_ready=0 for 10 cycles.
  - resp_valid, resp_data and resp_id stay stable; no req_ready pulses.
  - Release: response taken, next grant the following cycle.
- Multi-cycle core and timeout:
  - Core done delayed 3 cycles: start held until ap_ready, correct data.
  - Core done never asserted, TIMEOUT=16: resp_err=1, resp_data=0 after 16 WAIT cycles.
- Reset in WAIT:
  - ap_rst for 1 cycle mid-WAIT.
  - Next cycle: busy=0, core_ap_start=0, resp_valid=0, ptr=0.
